// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS x DATA_SIZE-bit registers with byte-lane writes.
// AW and W are held independently, and the write commits once both are present.
// A read returns registered data one cycle after its address handshake.
// Build option: define AXI_LITE_SLVERR_EN to answer out-of-range accesses with SLVERR (2'b10).
// Without it they complete with OKAY.
// Out-of-range writes are always dropped, and out-of-range reads always return 0.
module axi_lite_reg_slave #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned NUM_REGS  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_awvalid,
    output logic                   o_awready,
    input  logic [ADDR_SIZE-1:0]   i_awaddr,
    input  logic                   i_wvalid,
    output logic                   o_wready,
    input  logic [DATA_SIZE-1:0]   i_wdata,
    input  logic [DATA_SIZE/8-1:0] i_wstrb,
    output logic                   o_bvalid,
    input  logic                   i_bready,
    output logic [1:0]             o_bresp,
    input  logic                   i_arvalid,
    output logic                   o_arready,
    input  logic [ADDR_SIZE-1:0]   i_araddr,
    output logic                   o_rvalid,
    input  logic                   i_rready,
    output logic [DATA_SIZE-1:0]   o_rdata,
    output logic [1:0]             o_rresp
);

    localparam int unsigned STRB_W = DATA_SIZE / 8;
    localparam int unsigned OFFSET = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    // First byte address past the register file.
    localparam logic [ADDR_SIZE-1:0] ADDR_LIMIT = ADDR_SIZE'(NUM_REGS * STRB_W);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    logic [DATA_SIZE-1:0] r_regs [NUM_REGS];

    logic                 r_aw_held;
    logic [IDX_W-1:0]     r_aw_idx;
    logic                 r_aw_ok;
    logic                 r_w_held;
    logic [DATA_SIZE-1:0] r_w_data;
    logic [STRB_W-1:0]    r_w_strb;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;

    logic                 r_rvalid;
    logic [DATA_SIZE-1:0] r_rdata;
    logic [1:0]           r_rresp;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_ar_ok;

    // Ready outputs; all held low while reset is asserted.
    always_comb begin
        o_awready = i_reset_n && !r_aw_held && !r_bvalid;
        o_wready  = i_reset_n && !r_w_held && !r_bvalid;
        o_arready = i_reset_n && !r_rvalid;
    end

    // Handshake strobes and read-address decode.
    always_comb begin
        w_aw_hs = i_awvalid && o_awready;
        w_w_hs  = i_wvalid && o_wready;
        w_b_hs  = r_bvalid && i_bready;
        w_ar_hs = i_arvalid && o_arready;
        w_r_hs  = r_rvalid && i_rready;
        w_ar_ok = i_araddr < ADDR_LIMIT;
    end

    // Write path: capture AW/W, commit when both are held, then hold B until accepted.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_ok   <= 1'b0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= i_awaddr[OFFSET +: IDX_W];
                r_aw_ok   <= i_awaddr < ADDR_LIMIT;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= i_wdata;
                r_w_strb <= i_wstrb;
            end
            if (r_aw_held && r_w_held) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= r_aw_ok ? RESP_OKAY : RESP_OOR;
                if (r_aw_ok) begin
                    for (int b = 0; b < int'(STRB_W); b++) begin
                        if (r_w_strb[b]) begin
                            r_regs[r_aw_idx][8*b +: 8] <= r_w_data[8*b +: 8];
                        end
                    end
                end
            end else if (w_b_hs) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read path: register data and response on AR, then hold until R is accepted.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            if (w_ar_ok) begin
                r_rdata <= r_regs[i_araddr[OFFSET +: IDX_W]];
                r_rresp <= RESP_OKAY;
            end else begin
                r_rdata <= '0;
                r_rresp <= RESP_OOR;
            end
        end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
        end
    end

    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_rresp  = r_rresp;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave (DATA_SIZE=32, NUM_REGS=16).
// A flat array of register words acts as the reference memory.
// Directed cases are followed by randomized write and read traffic.
module tb_axi_lite_reg_slave;

    logic        clk;
    logic        reset_n;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

`ifdef AXI_LITE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference register contents.
    logic [31:0] mem [16];

    axi_lite_reg_slave #(
        .DATA_SIZE(32),
        .ADDR_SIZE(32),
        .NUM_REGS (16)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .i_awvalid(awvalid),
        .o_awready(awready),
        .i_awaddr (awaddr),
        .i_wvalid (wvalid),
        .o_wready (wready),
        .i_wdata  (wdata),
        .i_wstrb  (wstrb),
        .o_bvalid (bvalid),
        .i_bready (bready),
        .o_bresp  (bresp),
        .i_arvalid(arvalid),
        .o_arready(arready),
        .i_araddr (araddr),
        .o_rvalid (rvalid),
        .i_rready (rready),
        .o_rdata  (rdata),
        .o_rresp  (rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) mask = mask | (32'hFF << (8 * b));
        end
        return (old & ~mask) | (data & mask);
    endfunction

    // lead > 0: W precedes AW by lead cycles; lead < 0: AW precedes W; 0: same cycle.
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, input int stall);
        logic        in_range;
        logic [31:0] idx;
        int          gap;
        in_range = addr < 32'd64;
        idx      = addr >> 2;
        gap      = (lead < 0) ? -lead : lead;
        chk("aw_ready_idle", 32'(awready), 32'd1);
        chk("w_ready_idle", 32'(wready), 32'd1);
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        if (lead >= 0) wvalid = 1'b1;
        if (lead <= 0) awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        for (int k = 0; k < gap; k++) begin
            if (lead > 0) begin
                chk("aw_ready_wait", 32'(awready), 32'd1);
                chk("w_ready_held", 32'(wready), 32'd0);
            end else begin
                chk("w_ready_wait", 32'(wready), 32'd1);
                chk("aw_ready_held", 32'(awready), 32'd0);
            end
            tick();
        end
        if (lead > 0) begin
            awvalid = 1'b1;
            tick();
            awvalid = 1'b0;
        end else if (lead < 0) begin
            wvalid = 1'b1;
            tick();
            wvalid = 1'b0;
        end
        chk("b_early", 32'(bvalid), 32'd0);
        tick();
        chk("b_valid", 32'(bvalid), 32'd1);
        chk("b_resp", 32'(bresp), in_range ? 32'd0 : 32'(OOR_RESP));
        if (in_range) mem[idx] = merge(mem[idx], data, strb);
        for (int s = 0; s < stall; s++) begin
            chk("b_hold", 32'(bvalid), 32'd1);
            chk("aw_ready_bp", 32'(awready), 32'd0);
            chk("w_ready_bp", 32'(wready), 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b_clear", 32'(bvalid), 32'd0);
        chk("aw_ready_after_b", 32'(awready), 32'd1);
        chk("w_ready_after_b", 32'(wready), 32'd1);
    endtask

    task automatic read_txn(input logic [31:0] addr, input int delay);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = (addr < 32'd64) ? mem[addr >> 2] : 32'd0;
        exp_resp = (addr < 32'd64) ? 2'b00 : OOR_RESP;
        chk("ar_ready_idle", 32'(arready), 32'd1);
        araddr  = addr;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("r_valid", 32'(rvalid), 32'd1);
        chk("r_data", rdata, exp_data);
        chk("r_resp", 32'(rresp), 32'(exp_resp));
        chk("ar_ready_busy", 32'(arready), 32'd0);
        for (int d = 0; d < delay; d++) begin
            tick();
            chk("r_hold", 32'(rvalid), 32'd1);
            chk("r_data_stable", rdata, exp_data);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("r_clear", 32'(rvalid), 32'd0);
    endtask

    initial begin
        logic [31:0] old_val;
        logic [31:0] a;
        clk     = 1'b0;
        reset_n = 1'b0;
        awvalid = 1'b0;
        awaddr  = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        bready  = 1'b0;
        arvalid = 1'b0;
        araddr  = '0;
        rready  = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        tick();
        tick();
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_awready", 32'(awready), 32'd1);
        chk("rel_arready", 32'(arready), 32'd1);

        // Simultaneous AW/W, then read back
        write_txn(32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
        read_txn(32'h08, 0);

        // W three cycles ahead of AW with partial strobes
        write_txn(32'h10, 32'h11223344, 4'b0101, 3, 0);
        read_txn(32'h10, 1);
        chk("strobe_merge", mem[4], 32'h00220044);

        // AW ahead of W, zero strobes leave the register alone
        write_txn(32'h08, 32'h0, 4'h0, -2, 0);
        read_txn(32'h08, 0);

        // B backpressure for five cycles
        write_txn(32'h14, 32'hCAFEF00D, 4'hF, 0, 5);
        read_txn(32'h14, 0);

        // Out-of-range read and write; nothing may change
        read_txn(32'h40, 0);
        write_txn(32'h44, 32'hFFFFFFFF, 4'hF, 0, 0);
        for (int i = 0; i < 16; i++) read_txn(32'(i * 4), 0);

        // Read on the same edge the write commits returns the old value
        write_txn(32'h0C, 32'h12345678, 4'hF, 0, 0);
        old_val = mem[3];
        awaddr  = 32'h0C;
        wdata   = 32'hA5A5A5A5;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        araddr  = 32'h0C;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("coll_rvalid", 32'(rvalid), 32'd1);
        chk("coll_rdata_old", rdata, old_val);
        chk("coll_bvalid", 32'(bvalid), 32'd1);
        mem[3] = 32'hA5A5A5A5;
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        chk("coll_b_clear", 32'(bvalid), 32'd0);
        chk("coll_r_clear", 32'(rvalid), 32'd0);
        read_txn(32'h0C, 0);

        // Reset with a held W and an outstanding read
        wdata  = 32'h77777777;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        tick();
        wvalid  = 1'b0;
        araddr  = 32'h08;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        chk("mid_rst_arready", 32'(arready), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #1;
        chk("post_rst_wready", 32'(wready), 32'd1);
        // A lone AW must not pair with the discarded W
        awaddr  = 32'h10;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        chk("no_stale_w", 32'(bvalid), 32'd0);
        wdata  = 32'h00000055;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("late_w_early", 32'(bvalid), 32'd0);
        tick();
        chk("late_w_bvalid", 32'(bvalid), 32'd1);
        chk("late_w_bresp", 32'(bresp), 32'd0);
        mem[4] = 32'h00000055;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        for (int i = 0; i < 16; i++) read_txn(32'(i * 4), 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                write_txn(a, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
            end else begin
                read_txn(a, int'($urandom_range(0, 2)));
            end
        end
        for (int i = 0; i < 16; i++) read_txn(32'(i * 4), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 Parameter: DATA_SIZE, 32, data bus width in bits; legal values 32 or 64.
REQ-002 Parameter: ADDR_SIZE, 32, address bus width in bits.
REQ-003 Parameter: NUM_REGS, 16, number of DATA_SIZE-bit registers; power of two, 2..256.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: reset_n  input  1  reset; synchronous, active-low.
REQ-006 Port: awvalid/awready  input/output  1/1  write-address handshake.
REQ-007 Port: awaddr  input  ADDR_SIZE  write byte address.
REQ-008 Port: wvalid/wready  input/output  1/1  write-data handshake.
REQ-009 Port: wdata/wstrb  input  DATA_SIZE / DATA_SIZE/8  write data and byte-lane enables.
REQ-010 Port: bvalid/bready  output/input  1/1  write-response handshake.
REQ-011 Port: bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-012 Port: arvalid/arready  input/output  1/1  read-address handshake.
REQ-013 Port: araddr  input  ADDR_SIZE  read byte address.
REQ-014 Port: rvalid/rready  output/input  1/1  read-data handshake.
REQ-015 Port: rdata/rresp  output  DATA_SIZE/2  read data and read response.

Function
REQ-016 Handshake: a transfer occurs on any edge where valid and ready are both 1; once asserted, an output valid holds until its handshake.
REQ-017 Decode: word index = addr >> log2(DATA_SIZE/8); the low byte-offset bits are ignored; an address is in range iff addr < NUM_REGS*DATA_SIZE/8.
REQ-018 Write channels: AW and W are captured independently, in either order or in the same cycle, into holding registers aw_held and w_held.
REQ-019 Write ready rules: awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
REQ-020 Write execution: on the first edge at which aw_held && w_held, the addressed register is updated per byte lane where wstrb[i]=1, bvalid is set, and both holds clear.
REQ-021 Write latency: bvalid is visible one cycle after the later of the AW/W handshakes.
REQ-022 Write response: bvalid clears on the bready handshake; awready and wready return to 1 in the following cycle.
REQ-023 Read ready rule: arready = !rvalid.
REQ-024 Read execution: on an AR handshake at edge N, rdata/rresp are registered and rvalid=1 is visible after edge N; rdata and rresp are stable until the rready handshake.
REQ-025 Read/write collision: a read and a register write on the same edge to the same address return the pre-write value.
REQ-026 Write without strobes: wstrb=0 leaves the register unchanged and bresp=OKAY.
REQ-027 Channel independence: read and write channels operate concurrently with no mutual stall.

Reset
REQ-028 Reset values while reset_n=0 at an edge: all registers 0; bvalid, rvalid, bresp, rresp and rdata 0; holds cleared.
REQ-029 Ready gating: awready, wready and arready are 0 while reset_n=0 and become 1 in the first cycle after release.
REQ-030 Reset mid-transaction: a pending write or read is discarded with no response.

Configuration
REQ-031 Macro AXI_LITE_SLVERR_EN defined: an out-of-range write is dropped with bresp=2'b10; an out-of-range read returns rdata=0 with rresp=2'b10.
REQ-032 Macro AXI_LITE_SLVERR_EN undefined: out-of-range writes are dropped and out-of-range reads return 0, with response 2'b00 in both cases.

Verification (DATA_SIZE=32, NUM_REGS=16)
REQ-033 Simultaneous write: AW 0x08 and W 0xDEADBEEF with wstrb=4'hF in the same cycle -> bvalid next cycle with bresp=00; a later read of 0x08 returns 0xDEADBEEF with rresp=00.
REQ-034 Write order and strobes: W precedes AW by 3 cycles, wdata 0x11223344, wstrb=4'b0101 to a register holding 0 -> register = 0x00220044; awready stays 1 until AW arrives.
REQ-035 Backpressure: bready held 0 for 5 cycles -> bvalid stays 1, and awready/wready stay 0 for the whole period; a second AW is accepted only after the B handshake.
REQ-036 Out-of-range: read 0x40 and write 0x44 -> with the macro, rresp=bresp=10 and rdata=0; without the macro, responses are 00; no register changes in either build.
REQ-037 Collision and reset: a read of 0x0C on the same edge as a write of 0xA5A5A5A5 to 0x0C returns the old value; reset_n=0 asserted while rvalid=1 -> rvalid=0 and all registers 0 after the edge.
